// File: rtl/cpu_gpio_if.sv
// CPU-side register bus for the GPIO peripheral: single-cycle request, one-cycle ack.
interface cpu_gpio_if;
    logic        request;
    logic [3:0]  wmask;
    logic [1:0]  address;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output request, wmask, address, wdata, input ack, rdata);
    modport slave  (input request, wmask, address, wdata, output ack, rdata);
endinterface

// File: rtl/cpu_gpio.sv
// GPIO peripheral: synchronised inputs, per-bit edge detection, sticky pending flags,
// masked level interrupt and a small word-addressed register file.
module cpu_gpio #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    cpu_gpio_if.slave        bus,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [2:0]       arm_q, arm_d;
    logic [WIDTH-1:0] gpio_o_q, gpio_o_d;
    logic [WIDTH-1:0] gpio_oe_q, gpio_oe_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             irq_q, irq_d;
    logic             ack_q, ack_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [WIDTH-1:0] sync, rise, fall, set_bits, clr_bits;
    logic             armed, wr;
    logic [31:0]      rd_mux;

    function automatic logic [7:0] pad8(input logic [WIDTH-1:0] v);
        return 8'(v);
    endfunction

    always_comb begin
        sync_d[0] = gpio_i;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        sync   = sync_q[SYNC_STAGES-1];
        prev_d = sync;

        // Edges are ignored until the synchroniser and prev have settled after reset.
        armed = (arm_q == ARM_MAX);
        arm_d = armed ? arm_q : arm_q + 3'd1;
        rise  = armed ? (sync & ~prev_q) : '0;
        fall  = armed ? (~sync & prev_q) : '0;
        set_bits = (rise & rise_en_q) | (fall & fall_en_q);

        gpio_o_d  = gpio_o_q;
        gpio_oe_d = gpio_oe_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        mask_d    = mask_q;
        clr_bits  = '0;

        wr = bus.request && (bus.wmask != 4'b0000);
        if (wr) begin
            case (bus.address)
                2'd0: begin
                    if (bus.wmask[0]) gpio_o_d  = bus.wdata[WIDTH-1:0];
                    if (bus.wmask[1]) gpio_oe_d = bus.wdata[8 +: WIDTH];
                end
                2'd2: begin
                    if (bus.wmask[0]) rise_en_d = bus.wdata[WIDTH-1:0];
                    if (bus.wmask[1]) fall_en_d = bus.wdata[8 +: WIDTH];
                    if (bus.wmask[2]) mask_d    = bus.wdata[16 +: WIDTH];
                end
                2'd3: begin
                    if (bus.wmask[0]) clr_bits = bus.wdata[WIDTH-1:0];
                end
                default: ;
            endcase
        end

        // A new edge beats a simultaneous clear.
        pending_d = (pending_q & ~clr_bits) | set_bits;
        irq_d     = |(pending_q & mask_q);

        case (bus.address)
            2'd0:    rd_mux = {16'h0, pad8(gpio_oe_q), pad8(gpio_o_q)};
            2'd1:    rd_mux = {16'h0, pad8(pending_q), pad8(sync)};
            2'd2:    rd_mux = {8'h0, pad8(mask_q), pad8(fall_en_q), pad8(rise_en_q)};
            default: rd_mux = {24'h0, pad8(pending_q)};
        endcase

        ack_d   = bus.request;
        rdata_d = (bus.request && !wr) ? rd_mux : 32'h0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            prev_q    <= '0;
            arm_q     <= '0;
            gpio_o_q  <= '0;
            gpio_oe_q <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            mask_q    <= '0;
            pending_q <= '0;
            irq_q     <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            arm_q     <= arm_d;
            gpio_o_q  <= gpio_o_d;
            gpio_oe_q <= gpio_oe_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            mask_q    <= mask_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
        end
    end

    logic unused_wdata;
    assign unused_wdata = &{1'b0, bus.wdata};

    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
    assign gpio_o    = gpio_o_q;
    assign gpio_oe   = gpio_oe_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_cpu_gpio.sv
// Directed bench for cpu_gpio: register table plus edge/irq/reset sequences.
module tb_cpu_gpio;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] gpio_i;
    logic [7:0] gpio_o;
    logic [7:0] gpio_oe;
    logic       irq;

    cpu_gpio_if bus();

    cpu_gpio #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .gpio_i  (gpio_i),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [1:0]  addr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_o;
        logic [7:0]  exp_oe;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // Request is driven on a falling edge, sampled by the next rising edge,
    // and the ack is observed on the falling edge after that.
    task automatic xfer(input logic [1:0] a, input logic [3:0] m, input logic [31:0] d,
                        output logic [31:0] rd);
        @(negedge clk);
        bus.request = 1'b1;
        bus.address = a;
        bus.wmask   = m;
        bus.wdata   = d;
        @(negedge clk);
        chk("ack", {31'h0, bus.ack}, 32'h1);
        rd = bus.rdata;
        bus.request = 1'b0;
        bus.wmask   = 4'h0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] m, input logic [31:0] d);
        logic [31:0] rd;
        xfer(a, m, d, rd);
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        xfer(a, 4'h0, 32'h0, rd);
        chk(name, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;

        reset       = 1'b1;
        bus.request = 1'b0;
        bus.wmask   = 4'h0;
        bus.address = 2'd0;
        bus.wdata   = 32'h0;
        gpio_i      = 8'h0C;

        // Reset release with inputs already high: enable every edge immediately.
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'h0, bus.ack}, 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_gpio", {16'h0, gpio_oe, gpio_o}, 32'h0);
        reset       = 1'b0;
        bus.request = 1'b1;
        bus.address = 2'd2;
        bus.wmask   = 4'hF;
        bus.wdata   = 32'h00FF00FF;
        @(negedge clk);
        chk("arm_wr_ack", {31'h0, bus.ack}, 32'h1);
        bus.request = 1'b0;
        bus.wmask   = 4'h0;
        repeat (6) @(negedge clk);
        chk("arm_irq", {31'h0, irq}, 32'h0);
        rd_chk("arm_pending", 2'd3, 32'h0);
        rd_chk("arm_sync", 2'd1, 32'h0000000C);
        wr(2'd2, 4'hF, 32'h0);

        // Register table
        tbl.push_back('{2'd0, 4'b0001, 32'hFFFF0003, 32'h0,        8'h03, 8'h00});
        tbl.push_back('{2'd0, 4'b0000, 32'h0,        32'h00000003, 8'h03, 8'h00});
        tbl.push_back('{2'd0, 4'b0010, 32'hFFFFFFFF, 32'h0,        8'h03, 8'hFF});
        tbl.push_back('{2'd0, 4'b0000, 32'h0,        32'h0000FF03, 8'h03, 8'hFF});
        tbl.push_back('{2'd0, 4'b1100, 32'h00000000, 32'h0,        8'h03, 8'hFF});
        tbl.push_back('{2'd0, 4'b0000, 32'h0,        32'h0000FF03, 8'h03, 8'hFF});
        tbl.push_back('{2'd0, 4'b1111, 32'h12345A5A, 32'h0,        8'h5A, 8'h5A});
        tbl.push_back('{2'd0, 4'b0000, 32'h0,        32'h00005A5A, 8'h5A, 8'h5A});
        tbl.push_back('{2'd2, 4'b1111, 32'hFFFFFFFF, 32'h0,        8'h5A, 8'h5A});
        tbl.push_back('{2'd2, 4'b0000, 32'h0,        32'h00FFFFFF, 8'h5A, 8'h5A});
        tbl.push_back('{2'd2, 4'b0100, 32'h00000000, 32'h0,        8'h5A, 8'h5A});
        tbl.push_back('{2'd2, 4'b0000, 32'h0,        32'h0000FFFF, 8'h5A, 8'h5A});
        tbl.push_back('{2'd2, 4'b1111, 32'h00000000, 32'h0,        8'h5A, 8'h5A});
        tbl.push_back('{2'd2, 4'b0000, 32'h0,        32'h00000000, 8'h5A, 8'h5A});
        tbl.push_back('{2'd1, 4'b1111, 32'hFFFFFFFF, 32'h0,        8'h5A, 8'h5A});
        tbl.push_back('{2'd1, 4'b0000, 32'h0,        32'h0000000C, 8'h5A, 8'h5A});
        tbl.push_back('{2'd3, 4'b0000, 32'h0,        32'h00000000, 8'h5A, 8'h5A});

        foreach (tbl[i]) begin
            xfer(tbl[i].addr, tbl[i].wmask, tbl[i].wdata, rd);
            if (tbl[i].wmask == 4'h0) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_gpio", i), {16'h0, gpio_oe, gpio_o},
                {16'h0, tbl[i].exp_oe, tbl[i].exp_o});
        end

        // Rising edge on bit 2 -> irq after exactly 4 clocks
        gpio_i = 8'h08;
        repeat (4) @(negedge clk);
        wr(2'd2, 4'hF, 32'h00040004);
        gpio_i = 8'h0C;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("irq_lat_clk%0d", k), {31'h0, irq}, (k == 4) ? 32'h1 : 32'h0);
        end
        rd_chk("rise_status", 2'd1, 32'h0000040C);

        // W1C: zero write is a no-op, then a one clears; irq drops a cycle later
        wr(2'd3, 4'hF, 32'h0);
        rd_chk("w1c_zero", 2'd3, 32'h00000004);
        wr(2'd3, 4'hF, 32'h4);
        chk("w1c_irq_ack", {31'h0, irq}, 32'h1);
        @(negedge clk);
        chk("w1c_irq_fall", {31'h0, irq}, 32'h0);
        rd_chk("w1c_cleared", 2'd3, 32'h0);

        // Fall on bit 3 landing on the same edge as a W1C of bit 3
        wr(2'd2, 4'b0011, 32'h00000800);
        gpio_i = 8'h04;
        @(negedge clk);
        wr(2'd3, 4'hF, 32'h8);
        rd_chk("set_beats_clr", 2'd3, 32'h00000008);
        wr(2'd2, 4'hF, 32'h0);
        rd_chk("disable_keeps", 2'd3, 32'h00000008);
        wr(2'd3, 4'hF, 32'h8);
        rd_chk("clr_bit3", 2'd3, 32'h0);
        chk("irq_masked", {31'h0, irq}, 32'h0);

        // Back-to-back reads
        @(negedge clk);
        bus.request = 1'b1;
        bus.address = 2'd0;
        bus.wmask   = 4'h0;
        @(negedge clk);
        chk("b2b_ack0", {31'h0, bus.ack}, 32'h1);
        chk("b2b_rd0", bus.rdata, 32'h00005A5A);
        bus.address = 2'd1;
        @(negedge clk);
        bus.request = 1'b0;
        chk("b2b_ack1", {31'h0, bus.ack}, 32'h1);
        chk("b2b_rd1", bus.rdata, 32'h00000004);
        @(negedge clk);
        chk("b2b_idle", {31'h0, bus.ack}, 32'h0);
        chk("b2b_idle_rd", bus.rdata, 32'h0);

        // Reset landing in a read-ack cycle
        @(negedge clk);
        bus.request = 1'b1;
        bus.address = 2'd0;
        @(posedge clk);
        #2;
        bus.request = 1'b0;
        chk("pre_rst_ack", {31'h0, bus.ack}, 32'h1);
        chk("pre_rst_rd", bus.rdata, 32'h00005A5A);
        reset = 1'b1;
        #1;
        chk("mid_rst_ack", {31'h0, bus.ack}, 32'h0);
        chk("mid_rst_rd", bus.rdata, 32'h0);
        chk("mid_rst_gpio", {16'h0, gpio_oe, gpio_o}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        rd_chk("post_rst_r0", 2'd0, 32'h0);
        rd_chk("post_rst_r2", 2'd2, 32'h0);
        rd_chk("post_rst_r3", 2'd3, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
